axi4m_burst: RTL
================

AXI4M_BURST -- requirements
Module: axi4m_burst

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: AXI and request address width.
REQ-002 SHALL have parameter DATA_W, default 32: data width, 32 or 64 only; the strobe width is DATA_W/8.
REQ-003 SHALL have parameter ID_W, default 4: AXI ID width on every ID port.
REQ-004 SHALL have parameter TXN_ID, default 0: constant ID driven on awid/wid/arid.
REQ-005 SHALL have one clock and reset: clk in 1, the single clock; rst in 1, asynchronous active-high reset.
REQ-006 SHALL have the request ports:
  - req_valid in 1, request valid.
  - req_ready out 1, request accepted.
  - req_write in 1, 1 = write, 0 = read.
  - req_addr in ADDR_W, start byte address.
  - req_len in 8, beats minus 1.
  - req_wrap in 1, wrap burst request.
REQ-007 SHALL have the write-data ports:
  - wd_valid in 1, wd_ready out 1: write-data handshake.
  - wd_data in DATA_W, wd_strb in DATA_W/8: write data and byte strobes.
REQ-008 SHALL have the read-data ports:
  - rd_valid out 1, rd_ready in 1: read-data handshake.
  - rd_data out DATA_W: read data.
  - rd_last out 1: final beat of the burst.
REQ-009 SHALL have the completion ports: done out 1, one-cycle completion pulse; err out 2, the worst response seen in the burst.
REQ-010 SHALL provide the full AXI4 master port set (aw*, w*, b*, ar*, r*), each port sized by ADDR_W, DATA_W, ID_W and the package widths.

Function
REQ-011 SHALL run FSM IDLE->AR->R->IDLE for reads and IDLE->AW->W->B->IDLE for writes.
REQ-012 SHALL assert req_ready only in IDLE, and SHALL register addr/len/wrap/write on the req_valid&req_ready cycle.
REQ-013 SHALL hold arvalid/awvalid high, with stable payload, from the cycle after acceptance until the ready handshake.
REQ-014 SHALL drive axlen=req_len, axsize=log2(DATA_W/8), axburst=INCR(01) or WRAP(10), lock=0, cache=0011, prot=000, qos=0.
REQ-015 SHALL connect the W channel combinationally to wd_* in state W only (wvalid=wd_valid, wd_ready=wready).
REQ-016 SHALL count W beats with an 8-bit counter and SHALL assert wlast when the count equals the latched len.
REQ-017 SHALL never assert wvalid before the aw handshake has completed.
REQ-018 SHALL pass R straight through to rd_* (rready=rd_ready), and SHALL drive rd_last=rlast.
REQ-019 SHALL set bready=1 in state B.
REQ-020 SHALL update err on each R beat and on the B response as max(err, resp).
REQ-021 SHALL clear err on acceptance of a new request.
REQ-022 SHALL pulse done for one cycle on B accept (writes) or on the rlast beat (reads), and SHALL return to IDLE that same cycle.
REQ-023 SHALL, with len=0, issue a single beat with wlast/rlast set on the first beat.
REQ-024 SHALL treat an early rlast as the end of the burst and SHALL set err=2'b10 (SLVERR).
REQ-025 SHALL ignore rvalid, bvalid and wd_valid outside their own states.

Reset
REQ-026 SHALL, while rst is high, put the FSM in IDLE, clear the counter, and drive every valid output, done, err, wd_ready and bready to 0.
REQ-027 SHALL drop any in-flight burst on reset mid-operation and SHALL NOT replay it.

Configuration
REQ-028 SHALL, with AXI4M_WRAP_EN defined, honour req_wrap.
REQ-029 SHALL, when req_wrap=1 and len is not 1/3/7/15, or the address is unaligned to the transfer size, refuse the request by pulsing done with err=2'b10 and issuing no AXI traffic.
REQ-030 SHALL, without AXI4M_WRAP_EN, ignore req_wrap and always use INCR.

Structure
REQ-031 SHALL take the AXI width constants (SIZE/BURST/LOCK/CACHE/PROT/QOS/RESP widths) and the BURST_INCR/BURST_WRAP and RESP_* encodings from the shared package axi4_pkg.
REQ-032 SHALL keep the FSM and beat counter in the top module, with no sub-module.

Verification
REQ-033 SHALL pass: read addr 0x100, len 3, INCR, rresp OKAY -> araddr=0x100, arlen=3, arburst=01; 4 rd beats; rd_last on beat 4; done with err=0.
REQ-034 SHALL pass: write len 0, data 0xDEADBEEF, strb 0xF -> one W beat with wlast=1; done after bvalid with err=0.
REQ-035 SHALL pass: write len 7 with wready toggling every other cycle -> exactly 8 beats; wlast only on beat 8; wvalid never before the aw handshake.
REQ-036 SHALL pass: read len 3 where beat 2 has rresp=SLVERR -> err=2'b10 at done.
REQ-037 SHALL pass: rst asserted mid-write (beat 3 of 8) -> all valids low the same cycle; req_ready=1 after release.
REQ-038 SHALL pass, with AXI4M_WRAP_EN: wrap len 3 at 0x10C -> arburst=10. Wrap len 2 -> no arvalid; done with err=2'b10.

Source files
------------

// File: rtl/axi4_pkg.sv
// Shared AXI4 constants: channel field widths, burst and response encodings,
// and small helpers used by AXI masters in this codebase.
package axi4_pkg;

  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int LOCK_W  = 1;
  localparam int CACHE_W = 4;
  localparam int PROT_W  = 3;
  localparam int QOS_W   = 4;
  localparam int RESP_W  = 2;

  localparam logic [BURST_W-1:0] BURST_INCR = 2'b01;
  localparam logic [BURST_W-1:0] BURST_WRAP = 2'b10;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

  // Normal, non-allocating, bufferable/modifiable memory attribute
  localparam logic [CACHE_W-1:0] CACHE_DEFAULT = 4'b0011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW,
    ST_W,
    ST_B
  } burst_state_t;

  // WRAP bursts only exist for 2, 4, 8 or 16 beats
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  function automatic logic [RESP_W-1:0] resp_max(input logic [RESP_W-1:0] a,
                                                 input logic [RESP_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi4m_burst.sv
// Single-outstanding AXI4 burst master: one request becomes one AR/R or AW/W/B burst.
// Define AXI4M_WRAP_EN to honour req_wrap (with legality checking); otherwise all bursts are INCR.
module axi4m_burst
  import axi4_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int TXN_ID = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [7:0]           req_len,
  input  logic                 req_wrap,
  input  logic                 wd_valid,
  output logic                 wd_ready,
  input  logic [DATA_W-1:0]    wd_data,
  input  logic [DATA_W/8-1:0]  wd_strb,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 rd_last,
  output logic                 done,
  output logic [RESP_W-1:0]    err,
  output logic [ID_W-1:0]      awid,
  output logic [ADDR_W-1:0]    awaddr,
  output logic [7:0]           awlen,
  output logic [SIZE_W-1:0]    awsize,
  output logic [BURST_W-1:0]   awburst,
  output logic [LOCK_W-1:0]    awlock,
  output logic [CACHE_W-1:0]   awcache,
  output logic [PROT_W-1:0]    awprot,
  output logic [QOS_W-1:0]     awqos,
  output logic                 awvalid,
  input  logic                 awready,
  output logic [ID_W-1:0]      wid,
  output logic [DATA_W-1:0]    wdata,
  output logic [DATA_W/8-1:0]  wstrb,
  output logic                 wlast,
  output logic                 wvalid,
  input  logic                 wready,
  input  logic [ID_W-1:0]      bid,
  input  logic [RESP_W-1:0]    bresp,
  input  logic                 bvalid,
  output logic                 bready,
  output logic [ID_W-1:0]      arid,
  output logic [ADDR_W-1:0]    araddr,
  output logic [7:0]           arlen,
  output logic [SIZE_W-1:0]    arsize,
  output logic [BURST_W-1:0]   arburst,
  output logic [LOCK_W-1:0]    arlock,
  output logic [CACHE_W-1:0]   arcache,
  output logic [PROT_W-1:0]    arprot,
  output logic [QOS_W-1:0]     arqos,
  output logic                 arvalid,
  input  logic                 arready,
  input  logic [ID_W-1:0]      rid,
  input  logic [DATA_W-1:0]    rdata,
  input  logic [RESP_W-1:0]    rresp,
  input  logic                 rlast,
  input  logic                 rvalid,
  output logic                 rready
);

  localparam int SIZE = $clog2(DATA_W / 8);
  localparam logic [SIZE_W-1:0] AXSIZE = SIZE_W'(SIZE);
  localparam logic [ID_W-1:0]   AXID   = ID_W'(TXN_ID);

  burst_state_t          state;
  logic [ADDR_W-1:0]     addr_reg;
  logic [7:0]            len_reg;
  logic [BURST_W-1:0]    burst_reg;
  logic [7:0]            beat_cnt;
  logic [RESP_W-1:0]     err_reg;
  logic                  done_reg;
  logic                  awvalid_reg;
  logic                  arvalid_reg;

  logic                  wrap_req;
  logic                  wrap_bad;
  logic [RESP_W-1:0]     r_err;
  logic [RESP_W-1:0]     r_err_final;
  logic                  unused_ids;

`ifdef AXI4M_WRAP_EN
  assign wrap_req = req_wrap;
  assign wrap_bad = req_wrap & (!wrap_len_ok(req_len) || (req_addr[SIZE-1:0] != '0));
`else
  logic unused_wrap;
  assign unused_wrap = req_wrap;
  assign wrap_req    = 1'b0;
  assign wrap_bad    = 1'b0;
`endif

  assign unused_ids = ^{bid, rid};

  // An rlast that arrives before the expected final beat still ends the burst, but as SLVERR
  assign r_err       = resp_max(err_reg, rresp);
  assign r_err_final = (rlast && (beat_cnt != len_reg)) ? resp_max(r_err, RESP_SLVERR) : r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      addr_reg    <= '0;
      len_reg     <= '0;
      burst_reg   <= BURST_INCR;
      beat_cnt    <= '0;
      err_reg     <= RESP_OKAY;
      done_reg    <= 1'b0;
      awvalid_reg <= 1'b0;
      arvalid_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            addr_reg  <= req_addr;
            len_reg   <= req_len;
            burst_reg <= wrap_req ? BURST_WRAP : BURST_INCR;
            beat_cnt  <= '0;
            err_reg   <= RESP_OKAY;
            if (wrap_bad) begin
              done_reg <= 1'b1;
              err_reg  <= RESP_SLVERR;
            end else if (req_write) begin
              awvalid_reg <= 1'b1;
              state       <= ST_AW;
            end else begin
              arvalid_reg <= 1'b1;
              state       <= ST_AR;
            end
          end
        end
        ST_AR: begin
          if (arready) begin
            arvalid_reg <= 1'b0;
            state       <= ST_R;
          end
        end
        ST_R: begin
          if (rvalid && rd_ready) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (rlast) begin
              err_reg  <= r_err_final;
              done_reg <= 1'b1;
              state    <= ST_IDLE;
            end else begin
              err_reg <= r_err;
            end
          end
        end
        ST_AW: begin
          if (awready) begin
            awvalid_reg <= 1'b0;
            state       <= ST_W;
          end
        end
        ST_W: begin
          if (wd_valid && wready) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (beat_cnt == len_reg) state <= ST_B;
          end
        end
        ST_B: begin
          if (bvalid) begin
            err_reg  <= resp_max(err_reg, bresp);
            done_reg <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = (state == ST_IDLE);
  assign done      = done_reg;
  assign err       = err_reg;

  assign awid    = AXID;
  assign awaddr  = addr_reg;
  assign awlen   = len_reg;
  assign awsize  = AXSIZE;
  assign awburst = burst_reg;
  assign awlock  = '0;
  assign awcache = CACHE_DEFAULT;
  assign awprot  = '0;
  assign awqos   = '0;
  assign awvalid = awvalid_reg;

  assign arid    = AXID;
  assign araddr  = addr_reg;
  assign arlen   = len_reg;
  assign arsize  = AXSIZE;
  assign arburst = burst_reg;
  assign arlock  = '0;
  assign arcache = CACHE_DEFAULT;
  assign arprot  = '0;
  assign arqos   = '0;
  assign arvalid = arvalid_reg;

  // W is only opened once the address phase is over, which keeps wvalid behind the AW handshake
  assign wid      = AXID;
  assign wdata    = wd_data;
  assign wstrb    = wd_strb;
  assign wvalid   = (state == ST_W) & wd_valid;
  assign wd_ready = (state == ST_W) & wready;
  assign wlast    = (state == ST_W) & (beat_cnt == len_reg);

  assign rready   = (state == ST_R) & rd_ready;
  assign rd_valid = (state == ST_R) & rvalid;
  assign rd_data  = rdata;
  assign rd_last  = rlast;

  assign bready = (state == ST_B);

endmodule
